// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner for the 3-stage core: drives the sync-read instruction memory,
// delivers the decode instruction/PC and squashes wrong-path slots after a redirect.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] inst_rdata,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        flush_ex,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        KILL = 2'd2
    } state_e;

    state_e            state;
    state_e            state_nxt;
    logic [XLEN-1:0]   pc_f;
    logic [XLEN-1:0]   pc_f_nxt;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc_d_nxt;
    logic [XLEN-1:0]   count_nxt;
    logic [XLEN-1:0]   target_aligned;

    // Low target bits are dropped; misaligned targets are not trapped here.
    assign target_aligned = redirect_target & ~XLEN'(3);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_f        <= RESET_PC;
            pc_d        <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc_f        <= pc_f_nxt;
            pc_d        <= pc_d_nxt;
            fetch_count <= count_nxt;
        end
    end

    // Next-state, next-PC and decode-side outputs.
    always_comb begin
        state_nxt = state;
        pc_f_nxt  = pc_f;
        pc_d_nxt  = pc_d;
        count_nxt = fetch_count;
        flush_ex  = 1'b0;
        inst_id   = NOP_INST;

        if (state == RUN) begin
            inst_id = inst_rdata;
        end

        if (!stall) begin
            pc_d_nxt = pc_f;
            // The RUN-state instruction already reached ID, so it counts even if squashed in EX.
            if (state == RUN) begin
                count_nxt = fetch_count + XLEN'(1);
            end
            if (redirect) begin
                pc_f_nxt  = target_aligned;
                state_nxt = KILL;
                flush_ex  = 1'b1;
            end else begin
                pc_f_nxt  = pc_f + XLEN'(INST_BYTES);
                state_nxt = RUN;
            end
        end
    end

    assign imem_addr = pc_f;
    assign imem_en   = !stall;
    assign pc_id     = pc_d;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a sync-read memory that returns
// the fetched address as its data.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] inst_rdata;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        flush_ex;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    fetch_redirect_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .inst_rdata      (inst_rdata),
        .imem_addr       (imem_addr),
        .imem_en         (imem_en),
        .inst_id         (inst_id),
        .pc_id           (pc_id),
        .flush_ex        (flush_ex),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data equals the address presented on the previous enabled edge.
    always_ff @(posedge clk) begin
        if (imem_en) inst_rdata <= imem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_addr",   imem_addr,   RESET_PC);
        check("rst_inst",   inst_id,     NOP);
        check("rst_pc_id",  pc_id,       32'h0);
        check("rst_count",  fetch_count, 32'h0);
        check("rst_flush",  32'(flush_ex), 32'h0);
        #1 rst_n = 1'b1;

        // First enabled edge: RESET_PC data returns and is valid.
        tick();
        check("boot_addr",  imem_addr,   32'h4000_0004);
        check("boot_inst",  inst_id,     32'h4000_0000);
        check("boot_pc_id", pc_id,       32'h4000_0000);
        check("boot_count", fetch_count, 32'h0);
        tick();
        check("run_count",  fetch_count, 32'h1);
        check("run_inst",   inst_id,     32'h4000_0004);
        tick();
        tick();
        check("pre_redir_addr", imem_addr, 32'h4000_0010);

        // Taken redirect with a misaligned target.
        redirect        = 1'b1;
        redirect_target = 32'h1000_0006;
        #1;
        check("redir_flush", 32'(flush_ex), 32'h1);
        tick();
        redirect = 1'b0;
        #1;
        check("kill_addr",  imem_addr,   32'h1000_0004);
        check("kill_inst",  inst_id,     NOP);
        check("kill_flush", 32'(flush_ex), 32'h0);
        check("kill_count", fetch_count, 32'h4);
        tick();
        check("tgt_inst",   inst_id,     32'h1000_0004);
        check("tgt_pc_id",  pc_id,       32'h1000_0004);
        check("tgt_count",  fetch_count, 32'h4);

        // Plain stall for three edges.
        stall = 1'b1;
        #1;
        check("stall_en", 32'(imem_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  imem_addr,   32'h1000_0008);
            check("stall_inst",  inst_id,     32'h1000_0004);
            check("stall_pc_id", pc_id,       32'h1000_0004);
            check("stall_count", fetch_count, 32'h4);
        end
        stall = 1'b0;
        tick();
        check("unstall_count", fetch_count, 32'h5);
        check("unstall_inst",  inst_id,     32'h1000_0008);
        check("unstall_addr",  imem_addr,   32'h1000_000C);

        // Redirect held through a stall is acted on at release.
        stall           = 1'b1;
        redirect        = 1'b1;
        redirect_target = 32'h2000_0000;
        #1;
        check("sr_flush0", 32'(flush_ex), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sr_addr",  imem_addr,     32'h1000_000C);
            check("sr_flush", 32'(flush_ex), 32'h0);
        end
        stall = 1'b0;
        #1;
        check("sr_rel_flush", 32'(flush_ex), 32'h1);
        tick();
        check("sr_tgt_addr", imem_addr,   32'h2000_0000);
        check("sr_kill_inst", inst_id,    NOP);
        check("sr_count",    fetch_count, 32'h6);

        // Back-to-back redirect from KILL; newest target wins, low bits cleared.
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        #1;
        check("b2b_addr",  imem_addr,   32'hFFFF_FFFC);
        check("b2b_inst",  inst_id,     NOP);
        check("b2b_count", fetch_count, 32'h6);
        tick();
        check("wrap_addr",  imem_addr, 32'h0000_0000);
        check("wrap_inst",  inst_id,   32'hFFFF_FFFC);
        check("wrap_pc_id", pc_id,     32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", imem_addr,   32'h0000_0004);
        check("wrap_count", fetch_count, 32'h7);

        // Advance the counter to 56, then redirect into KILL with count 57.
        for (int i = 0; i < 49; i++) tick();
        check("count56", fetch_count, 32'd56);
        redirect        = 1'b1;
        redirect_target = 32'h3000_0000;
        tick();
        redirect = 1'b0;
        #1;
        check("k57_count", fetch_count, 32'd57);
        check("k57_inst",  inst_id,     NOP);

        // Asynchronous reset mid-cycle while in KILL.
        #1 rst_n = 1'b0;
        #1;
        check("arst_addr",  imem_addr,   RESET_PC);
        check("arst_count", fetch_count, 32'h0);
        check("arst_inst",  inst_id,     NOP);
        check("arst_pc_id", pc_id,       32'h0);
        #1 rst_n = 1'b1;
        tick();
        check("rerun_addr", imem_addr, 32'h4000_0004);
        check("rerun_inst", inst_id,   32'h4000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
